// File: rtl/serial_adder_if.sv
// Handshake and result bundle between a requester and serial_adder_ctrl.
// The ovf signal exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start_valid, a, b, c_in,
        input  start_ready, busy, done, sum, c_out
`ifdef SERIAL_ADD_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start_valid, a, b, c_in,
        output start_ready, busy, done, sum, c_out
`ifdef SERIAL_ADD_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one shared full adder, LSB first, WIDTH cycles per operation.
// Optional signed-overflow output enabled by macro SERIAL_ADD_OVF_EN.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ready;
    logic             r_busy;
    logic             r_done;
`ifdef SERIAL_ADD_OVF_EN
    logic             r_ovf;
`endif

    logic w_s;
    logic w_co;

    full_adder u_fa (
        .i_a (r_a[0]),
        .i_b (r_b[0]),
        .i_c (r_carry),
        .o_s (w_s),
        .o_c (w_co)
    );

    // Sequencing, operand shift registers and registered outputs; the visible
    // result only changes on the final RUN edge, so it stays stable mid-run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start_valid) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= bus.c_in;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_acc   <= {w_s, r_acc[WIDTH-1:1]};
                    r_carry <= w_co;
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_sum   <= {w_s, r_acc[WIDTH-1:1]};
                        r_cout  <= w_co;
`ifdef SERIAL_ADD_OVF_EN
                        // r_carry is the carry into the MSB on this last step
                        r_ovf   <= r_carry ^ w_co;
`endif
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                        r_state <= S_RUN;
                        r_done  <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.start_ready = r_ready;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.sum         = r_sum;
    assign bus.c_out       = r_cout;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.ovf         = r_ovf;
`endif
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed scoreboard bench for serial_adder_ctrl at WIDTH=8; checks ovf
// as well when SERIAL_ADD_OVF_EN is defined.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t q[$];

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands, wait (bounded) for acceptance, push the reference result.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        exp_t       e;
        logic [W:0] full;
        int         waited;
        bus.start_valid = 1'b1;
        bus.a           = a;
        bus.b           = b;
        bus.c_in        = ci;
        waited = 0;
        while (!bus.start_ready && waited < 20) begin
            step();
            waited++;
        end
        check("accept_ready", {63'd0, bus.start_ready}, 64'd1);
        full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        q.push_back(e);
        step();
        bus.start_valid = 1'b0;
        check("busy_after_accept",  {63'd0, bus.busy},        64'd1);
        check("ready_after_accept", {63'd0, bus.start_ready}, 64'd0);
        check("done_after_accept",  {63'd0, bus.done},        64'd0);
    endtask

    // Wait (bounded) for done, compare against the scoreboard, then check the idle return.
    task automatic wait_done();
        exp_t e;
        int   lat;
        int   busy_cyc;
        lat      = 0;
        busy_cyc = 1;
        e        = '0;
        while (!bus.done && lat < 20) begin
            step();
            lat++;
            if (bus.busy) busy_cyc++;
        end
        check("latency",      64'(lat),      64'(W));
        check("busy_cycles",  64'(busy_cyc), 64'(W + 1));
        check("ready_in_done", {63'd0, bus.start_ready}, 64'd0);
        check("sb_nonempty", {63'd0, (q.size() != 0)}, 64'd1);
        if (q.size() != 0) e = q.pop_front();
        check("sum",   64'(bus.sum),   64'(e.sum));
        check("c_out", {63'd0, bus.c_out}, {63'd0, e.cout});
`ifdef SERIAL_ADD_OVF_EN
        check("ovf",   {63'd0, bus.ovf},   {63'd0, e.ovf});
`endif
        step();
        check("done_one_cycle", {63'd0, bus.done},        64'd0);
        check("busy_cleared",   {63'd0, bus.busy},        64'd0);
        check("ready_restored", {63'd0, bus.start_ready}, 64'd1);
        check("sum_held",       64'(bus.sum),             64'(e.sum));
        check("c_out_held",     {63'd0, bus.c_out},       {63'd0, e.cout});
    endtask

    initial begin
        int done_seen;
        bus.start_valid = 1'b1;
        bus.a           = 8'hFF;
        bus.b           = 8'hFF;
        bus.c_in        = 1'b1;
        rst_n           = 1'b0;

        // Reset for two cycles while start_valid is asserted
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_sum",   64'(bus.sum),             64'd0);
            check("rst_c_out", {63'd0, bus.c_out},       64'd0);
            check("rst_done",  {63'd0, bus.done},        64'd0);
            check("rst_busy",  {63'd0, bus.busy},        64'd0);
            check("rst_ready", {63'd0, bus.start_ready}, 64'd1);
        end
        rst_n           = 1'b1;
        bus.start_valid = 1'b0;
        step();
        check("idle_busy",  {63'd0, bus.busy},        64'd0);
        check("idle_ready", {63'd0, bus.start_ready}, 64'd1);
        check("idle_sum",   64'(bus.sum),             64'd0);

        start_op(8'h0F, 8'h01, 1'b0);
        wait_done();
        start_op(8'hFF, 8'h01, 1'b0);
        wait_done();
        start_op(8'hFF, 8'hFF, 1'b1);
        wait_done();
        start_op(8'h7F, 8'h01, 1'b0);
        wait_done();
        start_op(8'hA5, 8'h5A, 1'b1);
        wait_done();

        // start_valid held with new operands throughout a run must be ignored
        start_op(8'h0F, 8'h01, 1'b0);
        bus.start_valid = 1'b1;
        bus.a           = 8'h01;
        bus.b           = 8'h01;
        bus.c_in        = 1'b0;
        wait_done();
        start_op(8'h01, 8'h01, 1'b0);
        wait_done();

        // Reset at the fourth RUN edge discards the operation
        start_op(8'h0F, 8'h01, 1'b0);
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        q.delete();
        check("midrst_busy",  {63'd0, bus.busy},        64'd0);
        check("midrst_ready", {63'd0, bus.start_ready}, 64'd1);
        check("midrst_sum",   64'(bus.sum),             64'd0);
        check("midrst_done",  {63'd0, bus.done},        64'd0);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.done) done_seen++;
        end
        check("midrst_no_done", 64'(done_seen), 64'd0);
        start_op(8'h3C, 8'h5A, 1'b1);
        wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-low.
REQ-002 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 start_valid  input  1  requester presents operands.
REQ-006 start_ready  output  1  controller can accept; high only in IDLE.
REQ-007 a  input  WIDTH  operand A, sampled on accept.
REQ-008 b  input  WIDTH  operand B, sampled on accept.
REQ-009 c_in  input  1  carry-in, sampled on accept.
REQ-010 busy  output  1  high in RUN and DONE.
REQ-011 done  output  1  one-cycle pulse; result valid.
REQ-012 sum  output  WIDTH  result, valid from done until next accept.
REQ-013 c_out  output  1  final carry, valid with sum.

Function
REQ-014 SHALL compute {c_out,sum} = a + b + c_in with one shared 1-bit full_adder instance, one bit per cycle, LSB first.
REQ-015 SHALL implement states IDLE, RUN, DONE; state encoding is free.
REQ-016 Accept = start_valid && start_ready at a rising edge; on accept, latch a, b and c_in into shift registers and carry flop, clear bit counter, go IDLE->RUN.
REQ-017 In RUN, each edge: full adder takes bit 0 of A/B shift regs and carry flop; sum bit shifts into sum MSB (right shift); carry flop takes adder carry; counter increments.
REQ-018 RUN->DONE on the edge where counter reaches WIDTH-1; RUN lasts exactly WIDTH cycles.
REQ-019 DONE lasts exactly one cycle with done=1; DONE->IDLE unconditionally.
REQ-020 Latency: done high in the cycle after the (WIDTH)th edge following the accept edge; next accept earliest in the cycle after done.
REQ-021 start_valid in RUN or DONE SHALL be ignored; operands SHALL not change mid-operation.
REQ-022 sum and c_out SHALL be undefined-for-use but stable-by-design during RUN; hold final value in DONE and IDLE until next accept.
REQ-023 Carry out of the MSB SHALL be dropped from sum and reported only on c_out; no wrap into bit 0.
REQ-024 done SHALL never be high in two consecutive cycles.

Reset
REQ-025 rst_n low at an edge SHALL force state IDLE regardless of state, including mid-RUN; partial result discarded, no done pulse.
REQ-026 Reset values: sum=0, c_out=0, done=0, busy=0, counter=0, carry flop=0; start_ready=1 in the first cycle after reset release.
REQ-027 start_valid during a reset cycle SHALL not be accepted.

Configuration
REQ-028 Macro SERIAL_ADD_OVF_EN SHALL control signed-overflow detection.
REQ-029 Defined: output port ovf (1 bit) SHALL exist; ovf = carry into MSB XOR carry out of MSB, updated on the DONE transition, held with sum, reset value 0.
REQ-030 Undefined: port ovf and its logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=8)
REQ-031 Reset then idle: rst_n low 2 cycles -> sum=0x00, c_out=0, done=0, busy=0, start_ready=1.
REQ-032 a=0x0F, b=0x01, c_in=0 accepted at edge 0 -> done high after edge 8, sum=0x10, c_out=0, busy high 9 cycles.
REQ-033 a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1; a=0xFF, b=0xFF, c_in=1 -> sum=0xFF, c_out=1.
REQ-034 start_valid held high with new operands (0x01,0x01) throughout a 0x0F+0x01 run -> result 0x10 unaffected; second op accepted only in the cycle after done, gives 0x02.
REQ-035 rst_n low at edge 4 of a run -> IDLE next cycle, sum=0x00, no done pulse; new op afterwards completes normally.
REQ-036 With SERIAL_ADD_OVF_EN: 0x7F+0x01 -> sum=0x80, ovf=1, c_out=0; 0xFF+0x01 -> ovf=0, c_out=1.
